// File: rtl/control_numarator.sv
// control_numarator: start/stop/hold counter with one-shot or auto-reload terminal count
module control_numarator #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done,
  output logic [7:0]       reload_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, limit_q, limit_d;
  logic             mode_q, mode_d, done_q, done_d;
  logic [7:0]       rel_q, rel_d;
  logic             at_limit;
  assign at_limit = cnt_q == limit_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    rel_d   = rel_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      cnt_d   = '0;
      rel_d   = '0;
      limit_d = limit;
      mode_d  = auto_reload;
    end else if (state_q == IDLE || state_q == DONE) begin
      cnt_d = load_en ? load_val : cnt_q;
    end else if (state_q == HOLD) begin
      state_d = hold ? HOLD : RUN;
    end else if (hold) begin
      state_d = HOLD;
    end else if (at_limit) begin
      // Terminal count: wrap and tally in auto-reload, park in DONE otherwise
      done_d  = 1'b1;
      state_d = mode_q ? RUN : DONE;
      cnt_d   = mode_q ? '0 : cnt_q;
      rel_d   = (mode_q && rel_q != 8'hFF) ? rel_q + 8'd1 : rel_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      rel_q   <= rel_d;
    end
  end
  assign q          = cnt_q;
  assign state      = state_q;
  assign busy       = state_q == RUN || state_q == HOLD;
  assign done       = done_q;
  assign reload_cnt = rel_q;
endmodule
